sr_bank_arbiter: RTL
====================

// Module: sr_bank_arbiter
// PURPOSE
//   Round-robin scheduler that shares one bank of NBITS SR flip-flops among NREQ requesters.
//   Each granted command becomes a single-cycle s or r pulse on one bank bit, so S=R=1 never reaches any bit.
//   Keeps a shadow copy of the bank state and counts issued pulses.
//   Sits between requester logic and the sr_ff bank; s_out/r_out wire straight to the bank's s/r inputs.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   NBITS  8   number of SR bits in the bank (>=2; need not be a power of 2)
//   IW     $clog2(NBITS)   index width (localparam, derived)
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous, active-low reset
//   req_valid  in   NREQ        bit i: requester i has a command pending
//   req_op     in   NREQ        bit i: 1 = set, 0 = reset
//   req_idx    in   NREQ*IW     requester i target bit at [i*IW +: IW]
//   clr_all    in   1           global clear request, highest priority
//   req_ready  out  NREQ        one-hot grant, combinational; command accepted when valid&ready at clk edge
//   s_out      out  NBITS       registered set pulses to bank
//   r_out      out  NBITS       registered reset pulses to bank
//   q_shadow   out  NBITS       registered bank state after the pulses currently on s_out/r_out
//   issue_cnt  out  16          pulses issued, wraps 16'hFFFF -> 0
//   err_oor    out  1           sticky: an out-of-range index (>= NBITS) was accepted
// BEHAVIOUR
//   - Reset (rst=0, async): s_out, r_out, q_shadow, issue_cnt = 0; err_oor = 0; rr pointer = 0; req_ready = 0.
//   - Arbitration: scan req_valid from ptr upward, wrapping mod NREQ; the first valid requester gets req_ready.
//     At most one req_ready bit is high. req_ready is 0 while clr_all=1 or while rst=0.
//   - Pointer: on an accepted grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
//   - Issue latency: a command accepted at edge k drives s_out[idx] (op=1) or r_out[idx] (op=0) high
//     for exactly the cycle after edge k. All other s_out/r_out bits are 0 in that cycle.
//     q_shadow[idx] updates at the same edge k. issue_cnt increments at edge k.
//   - Throughput: one command per cycle. Back-to-back grants give back-to-back pulses, one bit each.
//   - clr_all=1 at edge k: r_out <= all ones for one cycle; s_out <= 0; q_shadow <= 0; issue_cnt += 1.
//     No requester is accepted that cycle; pending requesters wait and ptr holds.
//     Held clr_all repeats the clear every cycle.
//   - Out-of-range idx (>= NBITS): the command is still granted and ptr advances. No pulse is issued,
//     q_shadow and issue_cnt are unchanged, and err_oor <= 1. Only reset clears err_oor.
//   - Invariant: (s_out & r_out) == 0 in every cycle, including after reset.
//   - Reset mid-pulse: s_out/r_out drop to 0 immediately; no pulse is reissued after reset release.
//   - Same bit targeted in consecutive cycles with opposite ops: both pulses issue, in grant order;
//     q_shadow follows the last one.
// CONFIGURATION
//   SR_SKIP_REDUNDANT_EN defined: a granted in-range command with req_op == q_shadow[idx] (evaluated
//     at the accept edge) is accepted and ptr advances, but no pulse is issued and issue_cnt is unchanged.
//     clr_all always pulses.
//   SR_SKIP_REDUNDANT_EN undefined: every accepted in-range command pulses and counts, even if redundant.
// TESTING
//   1. Hold rst=0 for 2 cycles, release, no requests -> all outputs 0 and req_ready=0 for 5 cycles.
//   2. req_valid=4'b0001, op=1, idx0=3 for one cycle -> req_ready=4'b0001 that cycle;
//      next cycle s_out=8'h08, r_out=0; q_shadow=8'h08; issue_cnt=1; cycle after that s_out=0.
//   3. All 4 valid, set, idx i=i, held -> grants 0,1,2,3 on consecutive cycles;
//      q_shadow=8'h0F after 4 grants; next grant goes back to 0.
//   4. q_shadow=8'h0F, clr_all=1 with req0 valid -> req_ready=0; next cycle r_out=8'hFF, q_shadow=0;
//      req0 granted the following cycle.
//   5. NBITS=6, req1 idx=7 -> granted, s_out=r_out=0, err_oor=1 held until rst=0.
//   6. Set idx3 twice, then rst=0 mid-pulse -> s_out=0 immediately. Before reset, issue_cnt=1 with
//      SR_SKIP_REDUNDANT_EN defined, 2 without it.

Source files
------------

// File: rtl/sr_bank_arbiter_if.sv
// Requester/bank bundle for sr_bank_arbiter: command handshake on one side,
// registered SR pulses plus shadow/status on the other.
interface sr_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
);
  localparam int IW = $clog2(NBITS);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*IW-1:0] req_idx;
  logic               clr_all;
  logic [NREQ-1:0]    req_ready;
  logic [NBITS-1:0]   s_out;
  logic [NBITS-1:0]   r_out;
  logic [NBITS-1:0]   q_shadow;
  logic [15:0]        issue_cnt;
  logic               err_oor;

  modport master (
    output req_valid, req_op, req_idx, clr_all,
    input  req_ready, s_out, r_out, q_shadow, issue_cnt, err_oor
  );

  modport slave (
    input  req_valid, req_op, req_idx, clr_all,
    output req_ready, s_out, r_out, q_shadow, issue_cnt, err_oor
  );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin scheduler turning requester commands into single-bit s/r pulses
// for an SR flip-flop bank. Optional feature macro: SR_SKIP_REDUNDANT_EN.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  sr_bank_arbiter_if.slave bus
);
  localparam int IW = $clog2(NBITS);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    ptr;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    gsel;
  logic             gvld;
  logic [IW-1:0]    sel_idx;
  logic             sel_op;
  logic             in_range;
  logic             skip;
  logic [NBITS-1:0] onehot;
  logic [PW-1:0]    ptr_nxt;
  logic [NBITS-1:0] s_q, r_q, q_q;
  logic [15:0]      cnt_q;
  logic             err_q;

  always_comb begin
    int j;
    j    = 0;
    grant = '0;
    gsel  = '0;
    gvld  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gvld && bus.req_valid[PW'(j)]) begin
        gvld = 1'b1;
        gsel = PW'(j);
      end
    end
    // clear and reset both suppress any grant
    if (bus.clr_all || !rst) gvld = 1'b0;
    if (gvld) grant[gsel] = 1'b1;
  end

  always_comb begin
    sel_idx = '0;
    sel_op  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gsel == PW'(i)) begin
        sel_idx = bus.req_idx[i*IW +: IW];
        sel_op  = bus.req_op[i];
      end
    end
    in_range = {1'b0, sel_idx} < (IW+1)'(NBITS);
    onehot   = NBITS'(1) << sel_idx;
    ptr_nxt  = (gsel == PW'(NREQ-1)) ? '0 : gsel + PW'(1);
`ifdef SR_SKIP_REDUNDANT_EN
    skip = (sel_op == |(q_q & onehot));
`else
    skip = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      s_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // pulses last one cycle unless re-armed below
      s_q <= '0;
      r_q <= '0;
      if (bus.clr_all) begin
        r_q   <= '1;
        q_q   <= '0;
        cnt_q <= cnt_q + 16'd1;
      end else if (gvld) begin
        ptr <= ptr_nxt;
        if (!in_range) begin
          err_q <= 1'b1;
        end else if (!skip) begin
          if (sel_op) begin
            s_q <= onehot;
            q_q <= q_q | onehot;
          end else begin
            r_q <= onehot;
            q_q <= q_q & ~onehot;
          end
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.s_out     = s_q;
  assign bus.r_out     = r_q;
  assign bus.q_shadow  = q_q;
  assign bus.issue_cnt = cnt_q;
  assign bus.err_oor   = err_q;
endmodule
